// File: rtl/ext_irq_source.sv
// ext_irq_source
// Bench-side external interrupt source for the P7 pipelined CPU.
// It watches the CPU macroscopic PC and raises an interrupt when the
// programmed trigger PC is reached. It holds the request until the CPU
// stores to ACK_ADDR. It then checks that the CPU entered the exception
// handler and left it within TIMEOUT cycles. This repeats trig_count times.
//
// Ports:
//   clk            in  1   rising-edge clock
//   reset          in  1   asynchronous active-low reset
//   enable         in  1   start/run; low aborts to IDLE
//   trig_pc        in  32  PC value that fires an interrupt (live compare in ARMED)
//   trig_count     in  8   interrupts to deliver, sampled when leaving IDLE
//   macroscopic_pc in  32  CPU macroscopic PC
//   m_data_addr    in  32  CPU data-bus address
//   m_data_byteen  in  4   CPU data-bus byte enables
//   interrupt      out 1   registered interrupt request
//   busy           out 1   high in ARMED, ASSERT, WAIT_RET
//   done           out 1   all interrupts served (sticky until IDLE)
//   err            out 1   timeout / handler never entered (sticky until IDLE)
//   spurious_ack   out 1   acknowledge seen outside ASSERT (sticky)
//   served_cnt     out 8   interrupts acknowledged and returned from (saturating)
module ext_irq_source #(
  parameter logic [31:0] ACK_ADDR   = 32'h0000_7F20,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] trig_pc,
  input  logic [7:0]  trig_count,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_data_addr,
  input  logic [3:0]  m_data_byteen,
  output logic        interrupt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        spurious_ack,
  output logic [7:0]  served_cnt
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_ASSERT = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t        state_q;
  logic          irq_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          spur_q;
  logic [7:0]    served_q;
  logic [7:0]    remaining_q;
  logic [TW-1:0] timer_q;
  logic          hseen_q;

  logic ack_s;
  logic in_handler_s;
  logic exit_s;

  // Decode acknowledge store, handler residency and handler exit.
  always_comb begin
    ack_s        = (m_data_addr == ACK_ADDR) && (m_data_byteen != 4'b0000);
    in_handler_s = (macroscopic_pc >= HANDLER_PC);
    exit_s       = hseen_q && !in_handler_s;
  end

  // Interrupt sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      spur_q      <= 1'b0;
      served_q    <= 8'h00;
      remaining_q <= 8'h00;
      timer_q     <= '0;
      hseen_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          irq_q <= 1'b0;
          if (enable) begin
            remaining_q <= trig_count;
            served_q    <= 8'h00;
            // A store on the start edge itself is still reported.
            spur_q      <= ack_s;
            hseen_q     <= 1'b0;
            if (trig_count == 8'h00) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ARMED;
              busy_q  <= 1'b1;
            end
          end else if (ack_s) begin
            spur_q <= 1'b1;
          end
        end

        S_ARMED: begin
          if (ack_s) begin
            spur_q <= 1'b1;
          end
          if (!enable) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (macroscopic_pc == trig_pc) begin
            state_q <= S_ASSERT;
            irq_q   <= 1'b1;
            timer_q <= '0;
            hseen_q <= 1'b0;
          end
        end

        S_ASSERT: begin
          if (!enable) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (ack_s) begin
            // Acknowledge beats a coincident timeout.
            state_q     <= S_WAIT;
            irq_q       <= 1'b0;
            remaining_q <= remaining_q - 8'd1;
            timer_q     <= timer_q + 1'b1;
            hseen_q     <= hseen_q | in_handler_s;
          end else if (timer_q == TLAST) begin
            state_q <= S_ERR;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
            hseen_q <= hseen_q | in_handler_s;
          end
        end

        S_WAIT: begin
          if (ack_s) begin
            spur_q <= 1'b1;
          end
          if (!enable) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (exit_s) begin
            // Exit beats a coincident timeout; a trig_pc match here is ignored.
            if (served_q != 8'hFF) begin
              served_q <= served_q + 8'd1;
            end
            if (remaining_q == 8'h00) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ARMED;
            end
          end else if (timer_q >= TLAST) begin
            // >= covers an ack taken on the last ASSERT cycle, which leaves
            // the timer already past TLAST.
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
            hseen_q <= hseen_q | in_handler_s;
          end
        end

        S_DONE, S_ERR: begin
          if (!enable) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          irq_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt    = irq_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign spurious_ack = spur_q;
  assign served_cnt   = served_q;

endmodule

// File: tb/tb_ext_irq_source.sv
// Directed testbench for ext_irq_source. Inputs change 1 ns after each rising
// edge; outputs are checked at that same point. Interrupt high cycles and
// rising edges are counted on falling edges.
module tb_ext_irq_source;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] trig_pc;
  logic [7:0]  trig_count;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [3:0]  be;
  logic        interrupt;
  logic        busy;
  logic        done;
  logic        err;
  logic        spurious_ack;
  logic [7:0]  served_cnt;

  int total;
  int bad;
  int hi_cyc;
  int pulses;
  logic prev_irq;
  int h0;
  int p0;

  ext_irq_source dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .trig_pc       (trig_pc),
    .trig_count    (trig_count),
    .macroscopic_pc(pc),
    .m_data_addr   (addr),
    .m_data_byteen (be),
    .interrupt     (interrupt),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .spurious_ack  (spurious_ack),
    .served_cnt    (served_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interrupt activity monitor.
  initial begin
    hi_cyc   = 0;
    pulses   = 0;
    prev_irq = 1'b0;
  end
  always @(negedge clk) begin
    if (interrupt === 1'b1) hi_cyc <= hi_cyc + 1;
    if (interrupt === 1'b1 && prev_irq !== 1'b1) pulses <= pulses + 1;
    prev_irq <= interrupt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] a, input logic [3:0] b);
    pc   = p;
    addr = a;
    be   = b;
  endtask

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    enable     = 1'b0;
    trig_pc    = 32'h0000_3010;
    trig_count = 8'd1;
    drive(32'h0000_3000, 32'h0, 4'h0);
    #2 reset = 1'b0;
    #1;
    chk("rst_irq",    {31'd0, interrupt},    32'd0);
    chk("rst_busy",   {31'd0, busy},         32'd0);
    chk("rst_done",   {31'd0, done},         32'd0);
    chk("rst_err",    {31'd0, err},          32'd0);
    chk("rst_spur",   {31'd0, spurious_ack}, 32'd0);
    chk("rst_served", {24'd0, served_cnt},   32'd0);
    tick();
    tick();
    reset = 1'b1;

    // ---- Single interrupt ----
    enable = 1'b1;
    tick();                                     // IDLE -> ARMED
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_armed_irq", {31'd0, interrupt}, 32'd0);
    h0 = hi_cyc;
    drive(32'h0000_3010, 32'h0, 4'h0);
    tick();                                     // match -> ASSERT
    chk("t1_irq_on", {31'd0, interrupt}, 32'd1);
    drive(32'h0000_4180, 32'h0, 4'h0);
    tick();                                     // CPU in handler
    chk("t1_irq_hold", {31'd0, interrupt}, 32'd1);
    drive(32'h0000_4184, 32'h0000_7F20, 4'hF);
    tick();                                     // ack -> WAIT_RET
    chk("t1_irq_off", {31'd0, interrupt}, 32'd0);
    drive(32'h0000_4190, 32'h0, 4'h0);
    tick();
    chk("t1_still_busy", {31'd0, busy}, 32'd1);
    drive(32'h0000_3010, 32'h0, 4'h0);
    tick();                                     // handler exit -> DONE
    chk("t1_served", {24'd0, served_cnt}, 32'd1);
    chk("t1_done",   {31'd0, done},       32'd1);
    chk("t1_err",    {31'd0, err},        32'd0);
    chk("t1_busy_end", {31'd0, busy},     32'd0);
    chk("t1_irq_cycles", hi_cyc - h0,     32'd2);
    enable = 1'b0;
    tick();
    chk("t1_done_clr", {31'd0, done}, 32'd0);

    // ---- Three interrupts on a looping PC ----
    trig_count = 8'd3;
    drive(32'h0000_3000, 32'h0, 4'h0);
    enable = 1'b1;
    tick();                                     // -> ARMED
    p0 = pulses;
    for (int k = 0; k < 3; k++) begin
      drive(32'h0000_3010, 32'h0, 4'h0);
      tick();
      chk("t2_irq_on", {31'd0, interrupt}, 32'd1);
      drive(32'h0000_4180, 32'h0, 4'h0);
      tick();
      drive(32'h0000_4188, 32'h0000_7F20, 4'h3);
      tick();
      chk("t2_irq_off", {31'd0, interrupt}, 32'd0);
      // Trigger PC seen while still in WAIT_RET must not re-fire.
      drive(32'h0000_3010, 32'h0, 4'h0);
      tick();
      chk("t2_no_refire", {31'd0, interrupt}, 32'd0);
      chk("t2_served", {24'd0, served_cnt}, k + 1);
      drive(32'h0000_3050, 32'h0, 4'h0);
      tick();
    end
    chk("t2_done",   {31'd0, done}, 32'd1);
    chk("t2_pulses", pulses - p0,   32'd3);
    enable = 1'b0;
    tick();

    // ---- Zero count goes straight to DONE ----
    trig_count = 8'd0;
    enable = 1'b1;
    tick();
    chk("t0_done", {31'd0, done}, 32'd1);
    chk("t0_busy", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    tick();

    // ---- No acknowledge: timeout ----
    trig_count = 8'd1;
    drive(32'h0000_3000, 32'h0, 4'h0);
    enable = 1'b1;
    tick();
    h0 = hi_cyc;
    drive(32'h0000_3010, 32'h0, 4'h0);
    tick();                                     // ASSERT
    drive(32'h0000_3014, 32'h0, 4'h0);
    for (int i = 0; i < 63; i++) tick();
    chk("t3_irq_before", {31'd0, interrupt}, 32'd1);
    chk("t3_err_before", {31'd0, err},       32'd0);
    tick();
    chk("t3_err", {31'd0, err},       32'd1);
    chk("t3_irq", {31'd0, interrupt}, 32'd0);
    tick();
    chk("t3_irq_cycles", hi_cyc - h0, 32'd64);
    enable = 1'b0;
    tick();
    chk("t3_err_clr", {31'd0, err}, 32'd0);

    // ---- Acknowledge without handler entry ----
    drive(32'h0000_3000, 32'h0, 4'h0);
    enable = 1'b1;
    tick();
    drive(32'h0000_3010, 32'h0, 4'h0);
    tick();                                     // ASSERT
    drive(32'h0000_3014, 32'h0000_7F20, 4'hF);
    tick();                                     // ack -> WAIT_RET
    drive(32'h0000_3018, 32'h0, 4'h0);
    for (int i = 0; i < 62; i++) tick();
    chk("t4_err_before", {31'd0, err}, 32'd0);
    tick();
    chk("t4_err",    {31'd0, err},          32'd1);
    chk("t4_served", {24'd0, served_cnt},   32'd0);
    chk("t4_spur",   {31'd0, spurious_ack}, 32'd0);
    enable = 1'b0;
    tick();

    // ---- Stray store while ARMED, then abort ----
    drive(32'h0000_3000, 32'h0, 4'h0);
    enable = 1'b1;
    tick();                                     // ARMED
    drive(32'h0000_3000, 32'h0000_7F20, 4'h0);
    tick();
    chk("t5_no_spur_be0", {31'd0, spurious_ack}, 32'd0);
    drive(32'h0000_3000, 32'h0000_7F20, 4'h1);
    tick();
    chk("t5_spur",      {31'd0, spurious_ack}, 32'd1);
    chk("t5_busy",      {31'd0, busy},         32'd1);
    chk("t5_irq_quiet", {31'd0, interrupt},    32'd0);
    drive(32'h0000_3010, 32'h0, 4'h0);
    tick();                                     // still ARMED, so it fires
    chk("t5_armed_fire", {31'd0, interrupt}, 32'd1);
    enable = 1'b0;
    tick();                                     // abort from ASSERT
    chk("t6_abort_irq",  {31'd0, interrupt},    32'd0);
    chk("t6_abort_busy", {31'd0, busy},         32'd0);
    chk("t6_spur_held",  {31'd0, spurious_ack}, 32'd1);

    // ---- Asynchronous reset mid-operation ----
    drive(32'h0000_3000, 32'h0, 4'h0);
    enable = 1'b1;
    tick();
    drive(32'h0000_3000, 32'h0000_7F20, 4'h4);
    tick();                                     // spurious store
    drive(32'h0000_3010, 32'h0, 4'h0);
    tick();                                     // ASSERT
    chk("t6_pre_irq", {31'd0, interrupt}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_irq",  {31'd0, interrupt},    32'd0);
    chk("t6_rst_busy", {31'd0, busy},         32'd0);
    chk("t6_rst_spur", {31'd0, spurious_ack}, 32'd0);
    chk("t6_rst_done", {31'd0, done},         32'd0);
    chk("t6_rst_err",  {31'd0, err},          32'd0);
    tick();
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_irq_source.md
# ext_irq_source

Testbench-side external interrupt source for the P7 pipelined CPU. It watches `macroscopic_pc` and raises `interrupt` when a programmed trigger PC is reached. It holds `interrupt` until the CPU acknowledges with a store to the interrupt acknowledge address. It then checks that the CPU entered the exception handler and left it within a cycle budget, and repeats for a programmed number of interrupts. It sits in the top-level bench next to the CPU and data memory model, and drives the CPU's `interrupt` input.

## Interface
- `ACK_ADDR`, 32'h7F20: data address whose store (any nonzero byte enable) acknowledges the interrupt.
- `HANDLER_PC`, 32'h4180: exception handler entry; PC ≥ this value counts as "in handler".
- `TIMEOUT`, 64: maximum cycles from raising `interrupt` to handler exit.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: start/run; low aborts to IDLE.
- `trig_pc` in 32: PC value that fires an interrupt.
- `trig_count` in 8: number of interrupts to deliver; sampled on leaving IDLE.
- `macroscopic_pc` in 32: CPU macroscopic PC.
- `m_data_addr` in 32: CPU data-bus address.
- `m_data_byteen` in 4: CPU data-bus byte enables.
- `interrupt` out 1: registered interrupt request to the CPU.
- `busy` out 1: high in ARMED, ASSERT, WAIT_RET.
- `done` out 1: all interrupts served; sticky.
- `err` out 1: timeout or handler never entered; sticky.
- `spurious_ack` out 1: sticky; set by an acknowledge while not in ASSERT.
- `served_cnt` out 8: interrupts acknowledged and returned from.

## Operation
- `ack` = (`m_data_addr` == `ACK_ADDR`) && (`m_data_byteen` != 0). It is combinational and sampled at each rising edge.
- State machine: IDLE, ARMED, ASSERT, WAIT_RET, DONE, ERR.
- IDLE:
  - `enable`=1 loads `remaining` ← `trig_count` and clears `served_cnt`, `spurious_ack` and `hseen`.
  - It then goes to DONE if `trig_count`==0, otherwise to ARMED.
- ARMED: `macroscopic_pc` == `trig_pc` → ASSERT. On the same edge `interrupt`←1, `timer`←0 and `hseen`←0.
- ASSERT:
  - `timer` increments each cycle.
  - `macroscopic_pc` ≥ `HANDLER_PC` sets `hseen`.
  - `ack` → WAIT_RET, with `interrupt`←0 and `remaining`←`remaining`−1.
- WAIT_RET:
  - `timer` keeps counting and `hseen` keeps updating.
  - Exit requires `hseen`=1 and `macroscopic_pc` < `HANDLER_PC`. On exit `served_cnt`+1, then go to DONE if `remaining`==0, otherwise to ARMED.
- Timeout: in ASSERT or WAIT_RET, `timer` == `TIMEOUT`−1 without the exit condition → ERR, with `interrupt`←0.
- DONE/ERR: hold outputs until `enable`=0, then go to IDLE. `done` and `err` clear on entry to IDLE.
- `enable`=0 in ARMED, ASSERT or WAIT_RET → IDLE next edge with `interrupt`←0. `served_cnt` holds its value.
- `ack` in ARMED, WAIT_RET or IDLE sets `spurious_ack`. It causes no state change.
- Widths and arithmetic:
  - `timer` is ⌈log2 `TIMEOUT`⌉+1 bits.
  - `served_cnt` saturates at 8'hFF.
  - `remaining` never underflows, because ASSERT is only entered with `remaining` ≥ 1.

## Timing
- Reset (asynchronous, `reset`=0) sets: state IDLE, `interrupt`=0, `busy`=0, `done`=0, `err`=0, `spurious_ack`=0, `served_cnt`=0, `timer`=0, `remaining`=0, `hseen`=0.
- All outputs are registered; none are combinational from inputs.
- PC match sampled at edge N → `interrupt`=1 from edge N to the edge that samples `ack`.
- `ack` sampled at edge M → `interrupt`=0 after edge M. `interrupt` is never dropped before an acknowledge except on timeout or abort.
- Simultaneous `ack` and timeout in ASSERT: `ack` wins and the block goes to WAIT_RET.
- Simultaneous exit condition and timeout in WAIT_RET: exit wins.
- `trig_pc` matching again in WAIT_RET is ignored. Re-arm happens only via ARMED, so the match must recur after handler exit.
- `trig_pc` and `trig_count` may change at any time; only the ARMED compare uses the live `trig_pc`.

## Test plan
- **Single interrupt.**
  - Stimulus: `trig_pc`=0x3010, `trig_count`=1, CPU model that stores to 0x7F20 one cycle after seeing `interrupt`, runs 0x4180–0x4190, then returns to 0x3010.
  - Required: `interrupt` high exactly 2 cycles; `served_cnt`=1; `done`=1; `err`=0.
- **Three interrupts on a looping PC (0x3000–0x30A0).**
  - Required: three `interrupt` pulses, each re-armed only after PC < 0x4180; `served_cnt`=3; `done`=1.
- **No acknowledge.**
  - Stimulus: CPU model never stores to 0x7F20.
  - Required: `interrupt` stays high for 64 cycles, then `err`=1 and `interrupt`=0.
- **Acknowledge without handler entry.**
  - Stimulus: acknowledge arrives but PC never reaches ≥ 0x4180.
  - Required: `err`=1 at the timeout; `served_cnt`=0.
- **Stray store.**
  - Stimulus: store to 0x7F20 with byteen=4'b0001 while ARMED.
  - Required: `spurious_ack`=1, state unchanged. The same address with byteen=0 does not set it.
- **Abort and reset mid-operation.**
  - Stimulus: drop `enable` in ASSERT, then assert `reset`=0 asynchronously between edges.
  - Required: `interrupt`=0 after the next edge from the abort; all outputs are at their reset values immediately when `reset`=0 is asserted, without waiting for a clock edge.
